// File: rtl/piso_serializer_if.sv
// Handshake bundle for the parallel-in, serial-out serializer.
// The parallel source drives i_data/i_valid and the serial sink drives i_en.
// The serializer returns o_ready and the serial stream with its framing flags.
interface piso_serializer_if #(
  parameter int WIDTH = 8
);

  logic [WIDTH-1:0] i_data;
  logic             i_valid;
  logic             o_ready;
  logic             i_en;
  logic             o_a;
  logic             o_valid;
  logic             o_first;
  logic             o_last;

  // Serializer side
  modport slave (
    input  i_data, i_valid, i_en,
    output o_ready, o_a, o_valid, o_first, o_last
  );

  // Source/sink side
  modport master (
    output i_data, i_valid, i_en,
    input  o_ready, o_a, o_valid, o_first, o_last
  );

endinterface

// File: rtl/piso_serializer.sv
// Parallel-in, serial-out converter.
// A WIDTH-bit word is taken over a valid/ready handshake and then emitted
// one bit per consumed cycle, with first/last framing flags.
// Back-to-back words stream with no gap, and i_en stalls the serial side.
// All outputs except o_ready come from registered state only. o_ready also
// depends on i_en, so that a new word can be loaded on the same edge that
// consumes the last bit of the current word.
module piso_serializer #(
  parameter int WIDTH     = 8,
  parameter bit LSB_FIRST = 1'b1
) (
  input  logic                   i_clk,
  input  logic                   i_rst_n,
  piso_serializer_if.slave       bus
);

  localparam int              CW       = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0]   LAST_IDX = CW'(WIDTH - 1);

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] shift_q, shift_d;
  logic [CW-1:0]    cnt_q,   cnt_d;

  logic at_last;
  logic ready;
  logic accept;
  logic out_bit;
  logic [WIDTH-1:0] shifted;

  assign at_last = (cnt_q == LAST_IDX);
  assign ready   = (state_q == IDLE) ||
                   ((state_q == SHIFT) && at_last && bus.i_en);
  assign accept  = bus.i_valid && ready;

  // The bit on the output is at the end of the register that sits nearest the output.
  // Vacated positions are filled with zero.
  assign out_bit = LSB_FIRST ? shift_q[0] : shift_q[WIDTH-1];
  assign shifted = LSB_FIRST ? {1'b0, shift_q[WIDTH-1:1]}
                             : {shift_q[WIDTH-2:0], 1'b0};

  // State, shift register and counter update on the rising edge; reset clears a word in flight.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= IDLE;
      shift_q <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next state logic: load on accept, shift on consume, go idle after the last bit if nothing is waiting.
  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          shift_d = bus.i_data;
          cnt_d   = '0;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        if (bus.i_en) begin
          if (at_last) begin
            if (bus.i_valid) begin
              shift_d = bus.i_data;
              cnt_d   = '0;
              state_d = SHIFT;
            end else begin
              shift_d = '0;
              cnt_d   = '0;
              state_d = IDLE;
            end
          end else begin
            shift_d = shifted;
            cnt_d   = cnt_q + CW'(1);
          end
        end
      end
      default: begin
        state_d = IDLE;
        shift_d = '0;
        cnt_d   = '0;
      end
    endcase
  end

  // Serial outputs and framing flags are decoded from registered state only.
  assign bus.o_valid = (state_q == SHIFT);
  assign bus.o_a     = (state_q == SHIFT) && out_bit;
  assign bus.o_first = (state_q == SHIFT) && (cnt_q == '0);
  assign bus.o_last  = (state_q == SHIFT) && at_last;
  assign bus.o_ready = ready;

endmodule

// File: tb/tb_piso_serializer.sv
// Testbench for piso_serializer.
// Two instances share one stimulus: busL has LSB_FIRST=1 and busM has LSB_FIRST=0.
// A word-level model holds the current word, the number of bits left and the
// bit position. Every cycle, the model gives the expected outputs.
module tb_piso_serializer;

  localparam int W = 8;

  logic         clk   = 1'b0;
  logic         rst_n = 1'b1;
  logic [W-1:0] dataIn [2];
  logic         validIn = 1'b0;
  logic         enIn    = 1'b0;

  int nCompared   = 0;
  int nMismatched = 0;

  piso_serializer_if #(.WIDTH(W)) busL ();
  piso_serializer_if #(.WIDTH(W)) busM ();

  assign busL.i_data  = dataIn[0];
  assign busL.i_valid = validIn;
  assign busL.i_en    = enIn;
  assign busM.i_data  = dataIn[1];
  assign busM.i_valid = validIn;
  assign busM.i_en    = enIn;

  piso_serializer #(.WIDTH(W), .LSB_FIRST(1'b1)) dutL (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .bus     (busL)
  );

  piso_serializer #(.WIDTH(W), .LSB_FIRST(1'b0)) dutM (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .bus     (busM)
  );

  // Free-running clock with a 10-unit period.
  always #5 clk = ~clk;

  // Word-level model: index 0 emits bit 0 first and index 1 emits bit W-1 first.
  logic [W-1:0] mWord   [2] = '{default: '0};
  int           mRemain [2] = '{0, 0};
  int           mPos    [2] = '{0, 0};
  bit           mAccepted = 1'b0;

  function automatic bit modelReady(int k);
    return (mRemain[k] == 0) || ((mRemain[k] == 1) && enIn);
  endfunction

  function automatic logic modelBit(int k);
    if (mRemain[k] == 0) return 1'b0;
    return (k == 0) ? mWord[k][mPos[k]] : mWord[k][W-1-mPos[k]];
  endfunction

  // The model advances on each clock edge. It consumes a bit if one is shown and
  // i_en is high, and then it loads a word on accept.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < 2; k++) begin
        mRemain[k] <= 0;
        mPos[k]    <= 0;
        mWord[k]   <= '0;
      end
      mAccepted <= 1'b0;
    end else begin
      for (int k = 0; k < 2; k++) begin
        int r;
        int p;
        r = mRemain[k];
        p = mPos[k];
        if (r > 0 && enIn) begin
          r = r - 1;
          p = p + 1;
        end
        if (validIn && modelReady(k)) begin
          mWord[k] <= dataIn[k];
          r = W;
          p = 0;
        end
        mRemain[k] <= r;
        mPos[k]    <= p;
      end
      mAccepted <= validIn && modelReady(0);
    end
  end

  // This task compares one value and records a mismatch.
  task automatic checkBit(input string name, input logic act, input logic exp);
    nCompared++;
    if (act !== exp) begin
      nMismatched++;
      $display("[TB] FAIL %s: got %b, expected %b at t=%0t", name, act, exp, $time);
    end
  endtask

  // This task compares every output of both instances with the model.
  task automatic checkOutput();
    checkBit("L o_valid", busL.o_valid, mRemain[0] > 0);
    checkBit("L o_a",     busL.o_a,     modelBit(0));
    checkBit("L o_first", busL.o_first, mRemain[0] == W);
    checkBit("L o_last",  busL.o_last,  mRemain[0] == 1);
    checkBit("L o_ready", busL.o_ready, modelReady(0));
    checkBit("M o_valid", busM.o_valid, mRemain[1] > 0);
    checkBit("M o_a",     busM.o_a,     modelBit(1));
    checkBit("M o_first", busM.o_first, mRemain[1] == W);
    checkBit("M o_last",  busM.o_last,  mRemain[1] == 1);
    checkBit("M o_ready", busM.o_ready, modelReady(1));
  endtask

  // The comparison with the model runs on every falling edge, away from the active edge.
  always @(negedge clk) checkOutput();

  // This task drives the source and sink inputs.
  task automatic applyStimulus(input logic v, input logic e,
                               input logic [W-1:0] dL, input logic [W-1:0] dM);
    validIn   = v;
    enIn      = e;
    dataIn[0] = dL;
    dataIn[1] = dM;
  endtask

  task automatic nextCycle();
    @(posedge clk);
    #1;
  endtask

  // The directed scenarios pin the model with literal expectations. Then a long
  // randomized run follows.
  initial begin : stim
    int exp1L [9]  = '{0, 1, 1, 0, 1, 0, 0, 1, 0};
    int exp1M [9]  = '{0, 0, 0, 1, 1, 1, 1, 0, 0};
    int exp2  [16] = '{1, 0, 0, 0, 0, 0, 0, 0, 1, 1, 1, 1, 1, 1, 1, 1};
    int en3   [12] = '{1, 1, 0, 0, 0, 1, 1, 1, 1, 1, 0, 1};
    int exp3  [12] = '{0, 1, 1, 1, 1, 1, 0, 1, 0, 0, 1, 1};
    int expAA [8]  = '{0, 1, 0, 1, 0, 1, 0, 1};
    int exp6  [8]  = '{0, 0, 0, 1, 1, 1, 1, 0};
    int got6  [8]  = '{0, 0, 0, 0, 0, 0, 0, 0};
    int nGot;

    dataIn[0] = '0;
    dataIn[1] = '0;

    // Assert reset before the first edge and check the reset outputs.
    #1 rst_n = 1'b0;
    #1;
    checkBit("reset L o_ready", busL.o_ready, 1'b1);
    checkBit("reset L o_valid", busL.o_valid, 1'b0);
    checkBit("reset L o_a",     busL.o_a,     1'b0);
    checkBit("reset M o_ready", busM.o_ready, 1'b1);
    #10 rst_n = 1'b1;
    nextCycle();

    // Scenario 1 sends a single word: 8'h96 on L (LSB first) and 8'h1E on M (MSB first).
    applyStimulus(1'b1, 1'b1, 8'h96, 8'h1E);
    @(negedge clk);
    checkBit("s1 ready on accept", busL.o_ready, 1'b1);
    nextCycle();
    validIn = 1'b0;
    for (int c = 0; c < 9; c++) begin
      @(negedge clk);
      checkBit("s1 L o_a",     busL.o_a,     exp1L[c][0]);
      checkBit("s1 M o_a",     busM.o_a,     exp1M[c][0]);
      checkBit("s1 L o_first", busL.o_first, c == 0);
      checkBit("s1 L o_last",  busL.o_last,  c == 7);
      checkBit("s1 M o_last",  busM.o_last,  c == 7);
      checkBit("s1 L o_valid", busL.o_valid, c < 8);
      nextCycle();
    end

    // Scenario 2 sends two words back to back: 8'h01 and then 8'hFF with i_valid held high.
    applyStimulus(1'b1, 1'b1, 8'h01, 8'h01);
    @(negedge clk);
    checkBit("s2 ready on accept", busL.o_ready, 1'b1);
    nextCycle();
    dataIn[0] = 8'hFF;
    dataIn[1] = 8'hFF;
    for (int c = 1; c <= 16; c++) begin
      @(negedge clk);
      checkBit("s2 L o_a",     busL.o_a,     exp2[c-1][0]);
      checkBit("s2 L o_valid", busL.o_valid, 1'b1);
      checkBit("s2 L o_first", busL.o_first, (c == 1) || (c == 9));
      checkBit("s2 L o_last",  busL.o_last,  (c == 8) || (c == 16));
      if (c < 16) checkBit("s2 L o_ready", busL.o_ready, c == 8);
      nextCycle();
      if (c == 8) validIn = 1'b0;
    end

    // Scenario 3 stalls on the third bit. It also stalls on the last bit while a new word waits.
    applyStimulus(1'b1, 1'b1, 8'h96, 8'h96);
    nextCycle();
    validIn = 1'b0;
    for (int c = 1; c <= 12; c++) begin
      enIn = en3[c-1][0];
      if (c == 11) begin
        validIn   = 1'b1;
        dataIn[0] = 8'h3C;
        dataIn[1] = 8'h3C;
      end
      @(negedge clk);
      checkBit("s3 L o_a",     busL.o_a,     exp3[c-1][0]);
      checkBit("s3 L o_valid", busL.o_valid, 1'b1);
      checkBit("s3 L o_ready", busL.o_ready, c == 12);
      nextCycle();
      if (c == 12) validIn = 1'b0;
    end
    enIn = 1'b1;
    repeat (9) nextCycle();

    // Scenario 4 raises i_valid with a new word during the second bit. The source waits for the last-bit consume.
    applyStimulus(1'b1, 1'b1, 8'h96, 8'h96);
    nextCycle();
    validIn = 1'b0;
    for (int c = 1; c <= 9; c++) begin
      if (c == 2) begin
        validIn   = 1'b1;
        dataIn[0] = 8'h0F;
        dataIn[1] = 8'h0F;
      end
      @(negedge clk);
      if (c >= 2 && c <= 7) checkBit("s4 L o_ready wait", busL.o_ready, 1'b0);
      if (c == 8)           checkBit("s4 L o_ready last", busL.o_ready, 1'b1);
      if (c == 9) begin
        checkBit("s4 L o_a new",     busL.o_a,     1'b1);
        checkBit("s4 L o_first new", busL.o_first, 1'b1);
      end
      nextCycle();
      if (c == 8) validIn = 1'b0;
    end
    repeat (8) nextCycle();

    // Scenario 5 asserts an asynchronous reset in the middle of a word. Then a clean 8'hAA follows.
    applyStimulus(1'b1, 1'b1, 8'h5A, 8'h5A);
    nextCycle();
    validIn = 1'b0;
    repeat (4) nextCycle();
    #2 rst_n = 1'b0;
    #1;
    checkBit("s5 L o_valid async", busL.o_valid, 1'b0);
    checkBit("s5 L o_a async",     busL.o_a,     1'b0);
    checkBit("s5 L o_first async", busL.o_first, 1'b0);
    checkBit("s5 L o_last async",  busL.o_last,  1'b0);
    checkBit("s5 L o_ready async", busL.o_ready, 1'b1);
    checkBit("s5 M o_valid async", busM.o_valid, 1'b0);
    @(posedge clk);
    @(posedge clk);
    #3 rst_n = 1'b1;
    nextCycle();
    applyStimulus(1'b1, 1'b1, 8'hAA, 8'hAA);
    nextCycle();
    validIn = 1'b0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      checkBit("s5 L o_a AA", busL.o_a, expAA[c][0]);
      nextCycle();
    end
    nextCycle();

    // Scenario 6 sends 8'h1E MSB first with i_en toggling. The bits are captured on consume cycles.
    applyStimulus(1'b1, 1'b1, 8'h1E, 8'h1E);
    nextCycle();
    validIn = 1'b0;
    nGot = 0;
    for (int c = 0; c < 16; c++) begin
      enIn = (c % 2 == 0);
      @(negedge clk);
      if (busM.o_valid && enIn) begin
        if (nGot < 8) got6[nGot] = int'(busM.o_a);
        nGot++;
      end
      nextCycle();
    end
    nCompared++;
    if (nGot != 8) begin
      nMismatched++;
      $display("[TB] FAIL s6 consume count: got %0d, expected 8", nGot);
    end
    for (int i = 0; i < 8; i++)
      checkBit("s6 M toggled bit", got6[i][0], exp6[i][0]);

    // Randomized phase: random i_en and random word arrivals, checked against the model.
    applyStimulus(1'b0, 1'b1, '0, '0);
    for (int i = 0; i < 3000; i++) begin
      if (validIn && mAccepted) begin
        if ($urandom_range(0, 1) == 1) begin
          dataIn[0] = W'($urandom);
          dataIn[1] = W'($urandom);
        end else begin
          validIn = 1'b0;
        end
      end
      enIn = ($urandom_range(0, 3) != 0);
      if (!validIn && $urandom_range(0, 2) == 0) begin
        validIn   = 1'b1;
        dataIn[0] = W'($urandom);
        dataIn[1] = W'($urandom);
      end
      nextCycle();
    end

    validIn = 1'b0;
    enIn    = 1'b1;
    repeat (10) nextCycle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule
